// File: rtl/actmem_rw_arbiter.sv
// actmem_rw_arbiter: shares the single-port activation banks between one word writer and one row reader,
// bounding write priority with a stall limit and tracking read validity/shift through the array latency.
module actmem_rw_arbiter #(
  parameter int NUMBANKS     = 24,
  parameter int BANKDEPTH    = 1024,
  parameter int WORDWIDTH    = 104,
  parameter int MAX_STALL    = 4,
  parameter int READ_LATENCY = 1,
  localparam int AW = $clog2(BANKDEPTH),
  localparam int BW = (NUMBANKS > 1) ? $clog2(NUMBANKS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [BW-1:0]                 wr_bank_i,
  input  logic [AW-1:0]                 wr_addr_i,
  input  logic [WORDWIDTH-1:0]          wr_data_i,
  input  logic                          rd_valid_i,
  output logic                          rd_ready_o,
  input  logic [NUMBANKS-1:0]           rd_bank_en_i,
  input  logic [NUMBANKS*AW-1:0]        rd_addr_i,
  input  logic [BW-1:0]                 rd_shift_i,
  output logic                          rd_rvalid_o,
  output logic [BW-1:0]                 rd_shift_o,
  output logic [NUMBANKS-1:0]           mem_read_enable_o,
  output logic [NUMBANKS-1:0]           mem_write_enable_o,
  output logic [NUMBANKS*AW-1:0]        mem_addr_o,
  output logic [NUMBANKS*WORDWIDTH-1:0] mem_wdata_o,
  input  logic [NUMBANKS-1:0]           mem_rw_collision_i,
  output logic                          err_o
);
  localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  logic [NUMBANKS-1:0]     wr_sel;
  logic                    bank_ok, conflict, stall_full, wr_grant, rd_grant;
  logic [SW-1:0]           stall_q, stall_d;
  logic                    err_q, err_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [BW-1:0]           sh_q [READ_LATENCY];
  logic [BW-1:0]           sh_d [READ_LATENCY];

  always_comb begin
    for (int b = 0; b < NUMBANKS; b++) wr_sel[b] = wr_bank_i == BW'(b);
  end

  // an out-of-range write bank selects nothing, so it can never conflict
  assign bank_ok    = |wr_sel;
  assign conflict   = rd_valid_i & wr_valid_i & |(rd_bank_en_i & wr_sel);
  assign stall_full = stall_q == SW'(MAX_STALL);
  assign wr_ready_o = wr_valid_i & ~(conflict & stall_full);
  assign rd_ready_o = rd_valid_i & ~(conflict & ~stall_full);
  assign wr_grant   = wr_valid_i & wr_ready_o;
  assign rd_grant   = rd_valid_i & rd_ready_o;
  assign stall_d    = (!rd_valid_i || rd_ready_o) ? '0 : stall_full ? stall_q : stall_q + 1'b1;
  assign err_d      = err_q | (wr_valid_i & ~bank_ok) | (|mem_rw_collision_i);

  always_comb begin
    mem_write_enable_o = wr_sel & {NUMBANKS{wr_grant}};
    mem_read_enable_o  = rd_bank_en_i & {NUMBANKS{rd_grant}} & ~mem_write_enable_o;
    mem_addr_o         = rd_addr_i;
    for (int b = 0; b < NUMBANKS; b++)
      mem_addr_o[b*AW +: AW] = mem_write_enable_o[b] ? wr_addr_i : rd_addr_i[b*AW +: AW];
  end

  assign mem_wdata_o = {NUMBANKS{wr_data_i}};

  // shift stages only load behind a valid entry, so the output stage keeps the last delivered shift
  always_comb begin
    vld_d    = (vld_q << 1) | READ_LATENCY'(rd_grant);
    sh_d[0]  = rd_grant ? rd_shift_i : sh_q[0];
    for (int i = 1; i < READ_LATENCY; i++) sh_d[i] = vld_q[i-1] ? sh_q[i-1] : sh_q[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) sh_q[i] <= '0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      sh_q    <= sh_d;
    end
  end

  assign rd_rvalid_o = vld_q[READ_LATENCY-1];
  assign rd_shift_o  = sh_q[READ_LATENCY-1];
  assign err_o       = err_q;
endmodule
